// File: rtl/commit_unit_pkg.sv
// Shared types and widths for the commit (retire) stage.
package commit_unit_pkg;

  localparam int unsigned ROB_W       = 6;
  localparam int unsigned PHYS_W      = 7;
  localparam int unsigned ARCH_W      = 5;
  localparam int unsigned ARCH_REGS_N = 32;

  typedef enum logic [0:0] {
    C_IDLE    = 1'b0,
    C_ST_WAIT = 1'b1
  } commit_state_t;

  typedef struct packed {
    logic              uses_rd;
    logic [ARCH_W-1:0] rd_arch;
    logic [PHYS_W-1:0] pd_new;
    logic [PHYS_W-1:0] pd_old;
    logic              is_store;
    logic              is_load;
    logic              is_branch;
    logic              mispredict;
  } rob_entry_t;

endpackage

// File: rtl/commit_unit_pd_free_fifo.sv
// Two-entry first-word-fall-through FIFO carrying freed physical registers.
module pd_free_fifo #(
  parameter int unsigned W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_valid,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data,
  output logic [1:0]   cnt
);

  logic [W-1:0] mem_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   cnt_q;
  logic         push;
  logic         pop;

  // Pop frees the head slot, so a push is accepted at full when it pops too.
  assign pop       = pop_ready && (cnt_q != 2'd0);
  assign push      = push_valid && ((cnt_q != 2'd2) || pop);
  assign pop_valid = (cnt_q != 2'd0);
  assign pop_data  = mem_q[rd_ptr_q];
  assign cnt       = cnt_q;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/commit_unit.sv
// Retire stage: pops the ROB head in order, updates the AMT, frees pd_old and
// handshakes stores with the store buffer. Optional perf counters: COMMIT_PERF_EN.
module commit_unit
  import commit_unit_pkg::*;
#(
  parameter int unsigned ROB_W_P   = ROB_W,
  parameter int unsigned PHYS_W_P  = PHYS_W,
  parameter int unsigned ARCH_REGS = ARCH_REGS_N
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rob_commit_valid,
  output logic                          rob_commit_ready,
  input  rob_entry_t                    rob_commit_entry,
  input  logic [ROB_W_P-1:0]            rob_commit_idx,
  output logic                          st_commit_valid,
  input  logic                          st_commit_ready,
  output logic [ROB_W_P-1:0]            st_commit_idx,
  output logic                          free_valid,
  input  logic                          free_ready,
  output logic [PHYS_W_P-1:0]           free_pd,
  input  logic                          flush_valid,
  output logic [ARCH_REGS*PHYS_W_P-1:0] amt_map,
  output logic [31:0]                   retired_cnt,
  output logic [31:0]                   store_cnt
);

  commit_state_t        state_q, state_d;
  logic [ROB_W_P-1:0]   st_idx_q;
  logic                 latch_st;
  logic [PHYS_W_P-1:0]  amt_q [ARCH_REGS];
  logic [1:0]           fifo_cnt;
  logic                 retire;
  logic                 do_free;
  logic                 unused_fields;

  assign unused_fields = ^{rob_commit_entry.is_load, rob_commit_entry.is_branch,
                           rob_commit_entry.mispredict};

  assign retire        = rob_commit_valid && rob_commit_ready;
  assign do_free       = retire && rob_commit_entry.uses_rd &&
                         (rob_commit_entry.rd_arch != '0);
  assign st_commit_idx = st_idx_q;

  // State register and latched store index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= C_IDLE;
      st_idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_st) begin
        st_idx_q <= rob_commit_idx;
      end
    end
  end

  // Next state and handshake outputs; flush overrides everything.
  always_comb begin
    state_d          = state_q;
    rob_commit_ready = 1'b0;
    st_commit_valid  = 1'b0;
    latch_st         = 1'b0;
    case (state_q)
      C_IDLE: begin
        if (rob_commit_valid && !flush_valid) begin
          if (rob_commit_entry.is_store) begin
            latch_st = 1'b1;
            state_d  = C_ST_WAIT;
          end else begin
            rob_commit_ready = (fifo_cnt < 2'd2);
          end
        end
      end
      C_ST_WAIT: begin
        if (flush_valid) begin
          state_d = C_IDLE;
        end else begin
          st_commit_valid = 1'b1;
          if (st_commit_ready) begin
            rob_commit_ready = 1'b1;
            state_d          = C_IDLE;
          end
        end
      end
      default: state_d = C_IDLE;
    endcase
  end

  // Architectural map table; x0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ARCH_REGS; i++) begin
        amt_q[i] <= PHYS_W_P'(i);
      end
    end else if (do_free) begin
      amt_q[rob_commit_entry.rd_arch] <= PHYS_W_P'(rob_commit_entry.pd_new);
    end
  end

  for (genvar g = 0; g < ARCH_REGS; g++) begin : g_amt
    assign amt_map[g*PHYS_W_P +: PHYS_W_P] = amt_q[g];
  end

  pd_free_fifo #(
    .W (PHYS_W_P)
  ) u_free_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (do_free),
    .push_data  (PHYS_W_P'(rob_commit_entry.pd_old)),
    .pop_valid  (free_valid),
    .pop_ready  (free_ready),
    .pop_data   (free_pd),
    .cnt        (fifo_cnt)
  );

`ifdef COMMIT_PERF_EN
  logic [31:0] retired_q;
  logic [31:0] store_q;

  // Retire and store counters; survive flush, wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= 32'd0;
      store_q   <= 32'd0;
    end else if (retire) begin
      retired_q <= retired_q + 32'd1;
      if (rob_commit_entry.is_store) begin
        store_q <= store_q + 32'd1;
      end
    end
  end

  assign retired_cnt = retired_q;
  assign store_cnt   = store_q;
`else
  assign retired_cnt = 32'd0;
  assign store_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_commit_unit.sv
// Scoreboard bench for commit_unit: transaction-level model predicts handshakes,
// AMT and freed registers; a monitor checks free/store traffic as it appears.
module tb_commit_unit;
  import commit_unit_pkg::*;

  localparam int unsigned PW   = PHYS_W;
  localparam int unsigned RW   = ROB_W;
  localparam int unsigned NREG = ARCH_REGS_N;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               rob_commit_valid = 1'b0;
  logic               rob_commit_ready;
  rob_entry_t         rob_commit_entry = '0;
  logic [RW-1:0]      rob_commit_idx = '0;
  logic               st_commit_valid;
  logic               st_commit_ready = 1'b0;
  logic [RW-1:0]      st_commit_idx;
  logic               free_valid;
  logic               free_ready = 1'b0;
  logic [PW-1:0]      free_pd;
  logic               flush_valid = 1'b0;
  logic [NREG*PW-1:0] amt_map;
  logic [31:0]        retired_cnt;
  logic [31:0]        store_cnt;

  always #5 clk = ~clk;

  commit_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rob_commit_valid (rob_commit_valid),
    .rob_commit_ready (rob_commit_ready),
    .rob_commit_entry (rob_commit_entry),
    .rob_commit_idx   (rob_commit_idx),
    .st_commit_valid  (st_commit_valid),
    .st_commit_ready  (st_commit_ready),
    .st_commit_idx    (st_commit_idx),
    .free_valid       (free_valid),
    .free_ready       (free_ready),
    .free_pd          (free_pd),
    .flush_valid      (flush_valid),
    .amt_map          (amt_map),
    .retired_cnt      (retired_cnt),
    .store_cnt        (store_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: current head, whether its store request is outstanding,
  // committed map, freed-register queue and counts.
  bit            head_valid;
  rob_entry_t    head;
  logic [RW-1:0] head_idx;
  bit            st_wait;
  logic [PW-1:0] m_amt [NREG];
  logic [PW-1:0] m_free [$];
  logic [PW-1:0] exp_free_q [$];
  logic [RW-1:0] exp_st_q [$];
  int unsigned   m_ret;
  int unsigned   m_st;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_amt[i] = PW'(i);
    m_free.delete();
    exp_free_q.delete();
    exp_st_q.delete();
    head_valid = 0;
    st_wait    = 0;
    m_ret      = 0;
    m_st       = 0;
  endtask

  task automatic set_head(input rob_entry_t e, input logic [RW-1:0] idx);
    head       = e;
    head_idx   = idx;
    head_valid = 1;
    if (e.is_store) exp_st_q.push_back(idx);
  endtask

  function automatic rob_entry_t rand_entry();
    rob_entry_t e;
    e            = '0;
    e.is_store   = ($urandom % 10) < 3;
    e.mispredict = 1'($urandom);
    e.is_branch  = 1'($urandom);
    if (!e.is_store) begin
      e.is_load = 1'($urandom);
      e.uses_rd = ($urandom % 5) != 0;
      e.rd_arch = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom);
      e.pd_new  = PW'($urandom);
      e.pd_old  = PW'($urandom);
    end
    return e;
  endfunction

  // Asynchronous reset applied mid-cycle, released away from the clock edge.
  task automatic do_reset();
    #2;
    rst_n            = 1'b0;
    rob_commit_valid = 1'b0;
    flush_valid      = 1'b0;
    st_commit_ready  = 1'b0;
    free_ready       = 1'b0;
    model_reset();
    #1;
    chk("rst_free_valid", free_valid, 1'b0);
    chk("rst_st_commit_valid", st_commit_valid, 1'b0);
    chk("rst_rob_ready", rob_commit_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  // One clock of stimulus: compare predicted handshakes/state, then advance the model.
  task automatic cycle(input bit fl, input bit sr, input bit fr);
    bit                 e_rdy;
    bit                 e_stv;
    bit                 ret;
    logic [NREG*PW-1:0] e_map;
    @(negedge clk);
    rob_commit_valid = head_valid;
    rob_commit_entry = head;
    rob_commit_idx   = head_idx;
    flush_valid      = fl;
    st_commit_ready  = sr;
    free_ready       = fr;
    #1;
    e_rdy = 0;
    e_stv = 0;
    if (!fl) begin
      if (st_wait) begin
        e_stv = 1;
        e_rdy = sr;
      end else if (head_valid && !head.is_store) begin
        e_rdy = m_free.size() < 2;
      end
    end
    chk("rob_commit_ready", rob_commit_ready, e_rdy);
    chk("st_commit_valid", st_commit_valid, e_stv);
    if (e_stv) chk("st_commit_idx", st_commit_idx, head_idx);
    chk("free_valid", free_valid, m_free.size() != 0);
    for (int i = 0; i < NREG; i++) e_map[i*PW +: PW] = m_amt[i];
    checks++;
    if (amt_map !== e_map) begin
      errors++;
      $display("FAIL amt_map: got %h expected %h at %0t", amt_map, e_map, $time);
    end
`ifdef COMMIT_PERF_EN
    chk("retired_cnt", retired_cnt, m_ret);
    chk("store_cnt", store_cnt, m_st);
`else
    chk("retired_cnt", retired_cnt, 32'd0);
    chk("store_cnt", store_cnt, 32'd0);
`endif
    ret = head_valid && e_rdy;
    if (fr && m_free.size() != 0) void'(m_free.pop_front());
    if (ret) begin
      m_ret++;
      if (head.is_store) m_st++;
      if (head.uses_rd && head.rd_arch != 0) begin
        m_amt[head.rd_arch] = head.pd_new;
        m_free.push_back(head.pd_old);
        exp_free_q.push_back(head.pd_old);
      end
      head_valid = 0;
      st_wait    = 0;
    end else if (fl) begin
      if (head_valid && head.is_store) void'(exp_st_q.pop_back());
      head_valid = 0;
      st_wait    = 0;
    end else if (head_valid && head.is_store) begin
      st_wait = 1;
    end
  endtask

  // Monitor: every free-list and store-buffer handshake must match the scoreboard.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (free_valid && free_ready) begin
        if (exp_free_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL free_pd: got %0h with no pending expectation at %0t", free_pd, $time);
        end else begin
          chk("free_pd", free_pd, exp_free_q.pop_front());
        end
      end
      if (st_commit_valid && st_commit_ready) begin
        if (exp_st_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL st_fire: got idx %0h with no pending store at %0t", st_commit_idx, $time);
        end else begin
          chk("st_fire_idx", st_commit_idx, exp_st_q.pop_front());
        end
      end
    end
  end

  initial begin
    rob_entry_t e;
    model_reset();
    head = '0;
    head_idx = '0;
    do_reset();
    cycle(0, 0, 0);
    cycle(0, 0, 0);

    // ALU rd=5: ready same cycle, amt[5]=40 and free_pd=5 afterwards.
    e = '0; e.uses_rd = 1; e.rd_arch = 5'd5; e.pd_new = PW'(40); e.pd_old = PW'(5);
    set_head(e, RW'(3));
    cycle(0, 0, 0);
    cycle(0, 0, 1);
    cycle(0, 0, 1);

    // Store idx 7: request after latch cycle, held off three cycles, then ack.
    e = '0; e.is_store = 1;
    set_head(e, RW'(7));
    cycle(0, 0, 1);
    for (int k = 0; k < 3; k++) cycle(0, 0, 1);
    cycle(0, 1, 1);
    cycle(0, 0, 1);

    // Free list back-pressure: third ALU retire stalls until a pop.
    for (int k = 0; k < 6; k++) begin
      if (!head_valid) begin
        e = '0; e.uses_rd = 1; e.rd_arch = 5'(k + 1);
        e.pd_new = PW'(50 + k); e.pd_old = PW'(k + 1);
        set_head(e, RW'(k));
      end
      cycle(0, 0, 0);
    end
    for (int k = 0; k < 5; k++) cycle(0, 0, 1);

    // Flush while waiting with ack present: nothing fires or retires.
    e = '0; e.is_store = 1;
    set_head(e, RW'(9));
    cycle(0, 0, 1);
    cycle(1, 1, 1);
    cycle(0, 1, 1);

    // rd_arch 0 retires without touching the AMT or the free list.
    e = '0; e.uses_rd = 1; e.rd_arch = 5'd0; e.pd_new = PW'(77); e.pd_old = PW'(66);
    set_head(e, RW'(11));
    cycle(0, 0, 1);
    cycle(0, 0, 1);

    // Randomized traffic with one mid-run asynchronous reset.
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      if (!head_valid && ($urandom % 4) != 0) set_head(rand_entry(), RW'($urandom));
      cycle(($urandom % 20) == 0, 1'($urandom), ($urandom % 3) != 0);
    end

    // Drain outstanding frees and any pending store.
    for (int n = 0; n < 10; n++) cycle(0, 1, 1);
    chk("free_drain", exp_free_q.size(), 0);
    chk("store_drain", exp_st_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
